dcache_sram_port: RTL and testbench
===================================

# dcache_sram_port

Single-clock request/response front-end for the 512x32 data-cache SRAM macro (simple dual-port, byte-enabled, 1-cycle unregistered read latency). Cache logic uses independent valid/ready write and read channels. This block registers writes into the SRAM write port, sequences reads through the fixed SRAM latency into a 4-entry response buffer, and resolves same-address read/write collisions. It sits between the D-cache controller and the SRAM instance.

## Interface
- ADDR_WIDTH, 9, SRAM word address width
- DATA_WIDTH, 32, word width
- BE_WIDTH, 4, byte enables (DATA_WIDTH/8)
- clk  in  1  single clock for both SRAM ports
- rst  in  1  reset, asynchronous, active-high
- wreq_valid / wreq_ready  in/out  1  write request handshake
- wreq_addr  in  ADDR_WIDTH; wreq_data  in  DATA_WIDTH; wreq_be  in  BE_WIDTH
- rreq_valid / rreq_ready  in/out  1  read request handshake
- rreq_addr  in  ADDR_WIDTH
- rresp_valid / rresp_ready  out/in  1  read response handshake
- rresp_data  out  DATA_WIDTH
- sram_wr_en  out  1; sram_wr_addr  out  ADDR_WIDTH; sram_wr_data  out  DATA_WIDTH; sram_wr_byte_en  out  BE_WIDTH
- sram_rd_addr  out  ADDR_WIDTH
- sram_rd_data  in  DATA_WIDTH  SRAM output, valid the cycle after the edge that samples sram_rd_addr

## Operation
- Transfer occurs on a rising edge with valid && ready. Requesters hold payload stable while valid && !ready.
- Write path: wreq_ready = 1 except during reset and the first edge after release. An accepted write is registered onto sram_wr_* with sram_wr_en = 1 for exactly one cycle, and the SRAM commits it on the next edge. Back-to-back writes run at 1/cycle.
- Read pipeline:
  - S1: accepted read registers sram_rd_addr and s1_valid.
  - S2: s2_valid follows s1_valid. sram_rd_data is valid while s2_valid = 1 and is pushed into the response FIFO at the following edge.
- Response FIFO: depth 4, in order. rresp_data is the FIFO head. rresp_valid = (count != 0).
- Credit rule: rreq_ready = !rst && (s1_valid + s2_valid + count) < 4. rresp_ready in the same cycle is not considered. This rule guarantees the FIFO never overflows and sustains 1 read/cycle while rresp_ready is held high.
- Collision: a read and a write with equal addresses accepted on the same edge would both reach the SRAM on the same edge, and the SRAM result is undefined in that case. Behaviour depends on the configuration macro (see Configuration).
- A write accepted one or more edges before a read to the same address is always visible to that read; no action is needed.
- Reset, whether idle or mid-operation:
  - in-flight reads and FIFO contents are discarded;
  - a registered write not yet committed is dropped (sram_wr_en forced to 0).

## Timing
- Reset values: wreq_ready 0, rreq_ready 0, rresp_valid 0, rresp_data 0, sram_wr_en 0, sram_wr_addr 0, sram_wr_data 0, sram_wr_byte_en 0, sram_rd_addr 0.
- After rst deasserts: wreq_ready and rreq_ready are 1 from the first edge onward.
- Write latency: request accepted at edge E0; sram_wr_en is high in cycle E0..E1; data is committed at E1.
- Read latency, with rresp_ready = 1 and the FIFO empty:
  - accepted at E0;
  - sram_rd_addr valid E0..E1;
  - sram_rd_data valid E1..E2;
  - rresp_valid = 1 from E2.
  - Total: 3 cycles from acceptance to response.
- FIFO full (count 4): a push cannot occur, by the credit rule. Simultaneous push and pop keep count unchanged. Pointers wrap modulo 4.

## Configuration
- DCACHE_SRAM_RAW_BYPASS_EN defined:
  - a same-edge same-address read is accepted normally;
  - the write's data and byte enables are captured alongside S1/S2;
  - at S2 the data pushed to the FIFO is the byte-wise merge: bytes with be = 1 take the write data, the rest take sram_rd_data.
  - No stall.
- Macro undefined:
  - rreq_ready is additionally forced to 0 in any cycle with wreq_valid && wreq_ready && wreq_addr == rreq_addr;
  - the write proceeds and the read is accepted on a later edge.
  - Adds exactly one stall cycle per collision.

## Test plan
- Fill/readback: write addr 0..511 with data 0xFFFF_FFFF - addr, be 4'hF, then read 0..511 with rresp_ready = 1 → 512 responses in order with matching data, 1 read/cycle after the first 3-cycle latency.
- Backpressure: hold rresp_ready = 0 and present 6 reads → exactly 4 accepted and rreq_ready = 0. Raise rresp_ready → 4 responses drain in order, then the remaining 2 are accepted; no loss or duplication.
- Byte enables: addr 0x10 = 0x11223344, then write 0xAABBCCDD with be 4'b0101, then read → 0x11BB33DD.
- Collision: addr 0x20 = 0x0; same edge write 0xDEADBEEF (be F) + read 0x20:
  - macro defined → response 0xDEADBEEF, no stall;
  - undefined → rreq_ready = 0 for 1 cycle, response 0xDEADBEEF.
- Reset mid-operation: 3 reads in flight and 2 in the FIFO, assert rst → all outputs go to reset values immediately. After release, rresp_valid stays 0 until new reads; reading a pre-reset address returns its committed data.

Source files
------------

// File: rtl/dcache_sram_port.sv
// dcache_sram_port: valid/ready front-end for the 512x32 byte-enabled simple
// dual-port data-cache SRAM (1-cycle read latency). Writes are registered onto
// the SRAM write port; reads go through a two-stage pipeline into a 4-entry
// in-order response FIFO protected by a credit rule.
// Optional feature: define DCACHE_SRAM_RAW_BYPASS_EN to forward the write data
// of a same-edge, same-address write into the colliding read. Without it, the
// read is stalled for one cycle instead.
module dcache_sram_port #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wreq_valid,
    output logic                  wreq_ready,
    input  logic [ADDR_WIDTH-1:0] wreq_addr,
    input  logic [DATA_WIDTH-1:0] wreq_data,
    input  logic [BE_WIDTH-1:0]   wreq_be,
    input  logic                  rreq_valid,
    output logic                  rreq_ready,
    input  logic [ADDR_WIDTH-1:0] rreq_addr,
    output logic                  rresp_valid,
    input  logic                  rresp_ready,
    output logic [DATA_WIDTH-1:0] rresp_data,
    output logic                  sram_wr_en,
    output logic [ADDR_WIDTH-1:0] sram_wr_addr,
    output logic [DATA_WIDTH-1:0] sram_wr_data,
    output logic [BE_WIDTH-1:0]   sram_wr_byte_en,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic [DATA_WIDTH-1:0] sram_rd_data
);

    localparam logic [2:0] CREDITS = 3'd4;

    logic                  started_q, started_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [BE_WIDTH-1:0]   wr_be_q, wr_be_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] fifo_q [4];
    logic [DATA_WIDTH-1:0] fifo_d [4];

    logic                  wr_fire, rd_fire, push, pop, same_addr;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] push_data;

`ifdef DCACHE_SRAM_RAW_BYPASS_EN
    logic                  byp1_q, byp1_d, byp2_q, byp2_d;
    logic [DATA_WIDTH-1:0] byp1_data_q, byp1_data_d, byp2_data_q, byp2_data_d;
    logic [BE_WIDTH-1:0]   byp1_be_q, byp1_be_d, byp2_be_q, byp2_be_d;
`endif

    // Handshakes, credit accounting and response outputs
    always_comb begin
        same_addr   = (wreq_addr == rreq_addr);
        occupancy   = {2'b00, s1_valid_q} + {2'b00, s2_valid_q} + count_q;
        wreq_ready  = started_q;
`ifdef DCACHE_SRAM_RAW_BYPASS_EN
        rreq_ready  = !rst && (occupancy < CREDITS);
`else
        rreq_ready  = !rst && (occupancy < CREDITS) && !(wreq_valid && wreq_ready && same_addr);
`endif
        wr_fire     = wreq_valid && wreq_ready;
        rd_fire     = rreq_valid && rreq_ready;
        rresp_valid = (count_q != 3'd0);
        rresp_data  = rresp_valid ? fifo_q[rd_ptr_q] : '0;
        pop         = rresp_valid && rresp_ready;
        push        = s2_valid_q;
    end

    // Data entering the FIFO: SRAM read data, optionally overlaid with forwarded write bytes
    always_comb begin
        push_data = sram_rd_data;
`ifdef DCACHE_SRAM_RAW_BYPASS_EN
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (byp2_q && byp2_be_q[b]) begin
                push_data[b*8 +: 8] = byp2_data_q[b*8 +: 8];
            end
        end
`endif
    end

    // Next-state for write register, read pipeline and FIFO bookkeeping
    always_comb begin
        started_d  = 1'b1;
        wr_en_d    = wr_fire;
        wr_addr_d  = wr_fire ? wreq_addr : wr_addr_q;
        wr_data_d  = wr_fire ? wreq_data : wr_data_q;
        wr_be_d    = wr_fire ? wreq_be   : wr_be_q;
        s1_valid_d = rd_fire;
        rd_addr_d  = rd_fire ? rreq_addr : rd_addr_q;
        s2_valid_d = s1_valid_q;
        wr_ptr_d   = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 3'd1;
        end else if (pop && !push) begin
            count_d = count_q - 3'd1;
        end
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_data;
        end
`ifdef DCACHE_SRAM_RAW_BYPASS_EN
        byp1_d      = rd_fire && wr_fire && same_addr;
        byp1_data_d = rd_fire ? wreq_data : byp1_data_q;
        byp1_be_d   = rd_fire ? wreq_be   : byp1_be_q;
        byp2_d      = byp1_q;
        byp2_data_d = byp1_data_q;
        byp2_be_d   = byp1_be_q;
`endif
    end

    // Control and pipeline state; reset drops in-flight reads, FIFO contents and any uncommitted write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            rd_addr_q  <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
        end else begin
            started_q  <= started_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
            rd_addr_q  <= rd_addr_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

`ifdef DCACHE_SRAM_RAW_BYPASS_EN
    // Forwarded write data travelling alongside the S1/S2 read stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
            byp1_data_q <= '0;
            byp2_data_q <= '0;
            byp1_be_q   <= '0;
            byp2_be_q   <= '0;
        end else begin
            byp1_q      <= byp1_d;
            byp2_q      <= byp2_d;
            byp1_data_q <= byp1_data_d;
            byp2_data_q <= byp2_data_d;
            byp1_be_q   <= byp1_be_d;
            byp2_be_q   <= byp2_be_d;
        end
    end
`endif

    // FIFO storage needs no reset: entries are only visible while count is non-zero
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign sram_wr_en      = wr_en_q;
    assign sram_wr_addr    = wr_addr_q;
    assign sram_wr_data    = wr_data_q;
    assign sram_wr_byte_en = wr_be_q;
    assign sram_rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_dcache_sram_port.sv
// Testbench for dcache_sram_port with a behavioural SRAM model and a
// scoreboard of expected read responses. Honours DCACHE_SRAM_RAW_BYPASS_EN.
`timescale 1ns/1ps
module tb_dcache_sram_port;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wreq_valid, wreq_ready, rreq_valid, rreq_ready;
    logic [AW-1:0] wreq_addr, rreq_addr;
    logic [DW-1:0] wreq_data;
    logic [BW-1:0] wreq_be;
    logic          rresp_valid, rresp_ready;
    logic [DW-1:0] rresp_data;
    logic          sram_wr_en;
    logic [AW-1:0] sram_wr_addr, sram_rd_addr;
    logic [DW-1:0] sram_wr_data, sram_rd_data;
    logic [BW-1:0] sram_wr_byte_en;

    int cmpCount = 0;
    int errCount = 0;
    int edgeCnt = 0;
    int rdAccCount = 0;
    int respCount = 0;
    int phaseId = 0;
    int seenPhase = 0;
    int firstAcc = -1;
    int firstPop = -1;
    int lastPop = -1;
    logic [DW-1:0] lastRespData = '0;

    logic [DW-1:0] sramMem [512];
    logic [DW-1:0] shadow [512];
    logic [DW-1:0] expQ [$];
    logic [DW-1:0] expVal;
    logic          pendWr = 1'b0;
    logic [AW-1:0] pendAddr;
    logic [DW-1:0] pendData;
    logic [BW-1:0] pendBe;

    always #5 clk = ~clk;

    dcache_sram_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
        .clk(clk), .rst(rst),
        .wreq_valid(wreq_valid), .wreq_ready(wreq_ready),
        .wreq_addr(wreq_addr), .wreq_data(wreq_data), .wreq_be(wreq_be),
        .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
        .rresp_valid(rresp_valid), .rresp_ready(rresp_ready), .rresp_data(rresp_data),
        .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
        .sram_wr_data(sram_wr_data), .sram_wr_byte_en(sram_wr_byte_en),
        .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data)
    );

    // SRAM model: byte-enabled write, read returns pre-write contents on a same-edge collision
    always @(posedge clk) begin
        edgeCnt <= edgeCnt + 1;
        if (sram_wr_en) begin
            for (int b = 0; b < BW; b++) begin
                if (sram_wr_byte_en[b]) sramMem[sram_wr_addr][b*8 +: 8] <= sram_wr_data[b*8 +: 8];
            end
        end
        sram_rd_data <= sramMem[sram_rd_addr];
    end

    function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] base, input logic [DW-1:0] d, input logic [BW-1:0] be);
        logic [DW-1:0] r = base;
        for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
        end
    endtask

    // Monitor on the falling edge: records handshakes that complete at the next rising edge
    always @(negedge clk) begin
        if (phaseId != seenPhase) begin
            seenPhase = phaseId;
            firstAcc  = -1;
            firstPop  = -1;
        end
        if (rst) begin
            expQ.delete();
            pendWr = 1'b0;
        end else begin
            if (pendWr) begin
                shadow[pendAddr] = mergeBytes(shadow[pendAddr], pendData, pendBe);
                pendWr = 1'b0;
            end
            if (wreq_valid && wreq_ready) begin
                pendWr   = 1'b1;
                pendAddr = wreq_addr;
                pendData = wreq_data;
                pendBe   = wreq_be;
            end
            if (rreq_valid && rreq_ready) begin
                expVal = shadow[rreq_addr];
                if (pendWr && pendAddr == rreq_addr) expVal = mergeBytes(expVal, pendData, pendBe);
                expQ.push_back(expVal);
                rdAccCount++;
                if (firstAcc < 0) firstAcc = edgeCnt + 1;
            end
            if (rresp_valid && rresp_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("resp_unexpected", expQ.size(), 1);
                end else begin
                    expVal = expQ.pop_front();
                    checkOutput("resp_data", rresp_data, expVal);
                end
                lastRespData = rresp_data;
                respCount++;
                if (firstPop < 0) firstPop = edgeCnt + 1;
                lastPop = edgeCnt + 1;
            end
        end
    end

    task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [BW-1:0] wbe, input logic rv, input logic [AW-1:0] ra);
        wreq_valid = wv; wreq_addr = wa; wreq_data = wd; wreq_be = wbe;
        rreq_valid = rv; rreq_addr = ra;
    endtask

    task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        int waited = 0;
        applyStimulus(1'b1, a, d, be, 1'b0, '0);
        @(negedge clk);
        while (!wreq_ready && waited < 20) begin @(negedge clk); waited++; end
        if (!wreq_ready) checkOutput("wr_accept_timeout", wreq_ready, 1);
        @(posedge clk); #1;
        wreq_valid = 1'b0;
    endtask

    task automatic readWord(input logic [AW-1:0] a);
        int waited = 0;
        rreq_valid = 1'b1; rreq_addr = a;
        @(negedge clk);
        while (!rreq_ready && waited < 20) begin @(negedge clk); waited++; end
        if (!rreq_ready) checkOutput("rd_accept_timeout", rreq_ready, 1);
        @(posedge clk); #1;
        rreq_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while ((expQ.size() != 0 || rresp_valid) && waited < 60) begin @(posedge clk); #1; waited++; end
        if (expQ.size() != 0 || rresp_valid) checkOutput("drain_timeout", expQ.size(), 0);
    endtask

    initial begin
        int accBase, respBase;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        rresp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_wreq_ready", wreq_ready, 0);
        checkOutput("rst_rreq_ready", rreq_ready, 0);
        checkOutput("rst_rresp_valid", rresp_valid, 0);
        checkOutput("rst_rresp_data", rresp_data, 0);
        checkOutput("rst_sram_wr_en", sram_wr_en, 0);
        checkOutput("rst_sram_rd_addr", sram_rd_addr, 0);
        @(negedge clk); rst = 1'b0; #1;
        checkOutput("pre_edge_wreq_ready", wreq_ready, 0);
        @(posedge clk); #1;
        checkOutput("post_rst_wreq_ready", wreq_ready, 1);
        checkOutput("post_rst_rreq_ready", rreq_ready, 1);

        // Fill every word, checking the registered write port once
        writeWord(9'd0, 32'hFFFF_FFFF, 4'hF);
        checkOutput("wr_en_after_accept", sram_wr_en, 1);
        checkOutput("wr_addr_after_accept", sram_wr_addr, 0);
        checkOutput("wr_data_after_accept", sram_wr_data, 32'hFFFF_FFFF);
        for (int a = 1; a < 512; a++) writeWord(a[8:0], 32'hFFFF_FFFF - a, 4'hF);
        @(posedge clk); #1;
        checkOutput("wr_en_one_cycle", sram_wr_en, 0);

        // Readback at full rate
        phaseId = 1;
        respBase = respCount;
        for (int a = 0; a < 512; a++) readWord(a[8:0]);
        waitDrain();
        checkOutput("fill_resp_count", respCount - respBase, 512);
        checkOutput("fill_first_latency", firstPop - firstAcc, 3);
        checkOutput("fill_span", lastPop - firstAcc, 514);

        // Byte enables
        writeWord(9'h010, 32'h1122_3344, 4'hF);
        writeWord(9'h010, 32'hAABB_CCDD, 4'b0101);
        readWord(9'h010);
        waitDrain();
        checkOutput("be_merge_value", lastRespData, 32'h11BB_33DD);

        // Same-edge write/read collision
        writeWord(9'h020, 32'h0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        accBase = rdAccCount;
        applyStimulus(1'b1, 9'h020, 32'hDEAD_BEEF, 4'hF, 1'b1, 9'h020);
        @(negedge clk);
`ifdef DCACHE_SRAM_RAW_BYPASS_EN
        checkOutput("coll_rreq_ready", rreq_ready, 1);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
`else
        checkOutput("coll_rreq_ready", rreq_ready, 0);
        @(posedge clk); #1;
        wreq_valid = 1'b0;
        @(negedge clk);
        checkOutput("coll_rreq_ready_next", rreq_ready, 1);
        @(posedge clk); #1;
        rreq_valid = 1'b0;
`endif
        waitDrain();
        checkOutput("coll_accepts", rdAccCount - accBase, 1);
        checkOutput("coll_data", lastRespData, 32'hDEAD_BEEF);

        // Backpressure: only four reads fit while responses are held
        rresp_ready = 1'b0;
        accBase = rdAccCount;
        respBase = respCount;
        for (int a = 'h100; a < 'h104; a++) readWord(a[8:0]);
        rreq_valid = 1'b1; rreq_addr = 9'h104;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_accepted", rdAccCount - accBase, 4);
        checkOutput("bp_rreq_ready", rreq_ready, 0);
        checkOutput("bp_head_data", rresp_data, 32'hFFFF_FEFF);
        @(posedge clk); #1;
        rresp_ready = 1'b1;
        readWord(9'h104);
        readWord(9'h105);
        waitDrain();
        checkOutput("bp_accepted_total", rdAccCount - accBase, 6);
        checkOutput("bp_resp_total", respCount - respBase, 6);

        // Reset with reads in flight, a full-ish FIFO and an uncommitted write
        rresp_ready = 1'b0;
        readWord(9'h040);
        readWord(9'h041);
        readWord(9'h042);
        applyStimulus(1'b1, 9'h030, 32'h1234_5678, 4'hF, 1'b1, 9'h043);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        checkOutput("pre_rst_wr_en", sram_wr_en, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_wreq_ready", wreq_ready, 0);
        checkOutput("mid_rst_rreq_ready", rreq_ready, 0);
        checkOutput("mid_rst_rresp_valid", rresp_valid, 0);
        checkOutput("mid_rst_rresp_data", rresp_data, 0);
        checkOutput("mid_rst_sram_wr_en", sram_wr_en, 0);
        checkOutput("mid_rst_sram_wr_addr", sram_wr_addr, 0);
        checkOutput("mid_rst_sram_wr_data", sram_wr_data, 0);
        checkOutput("mid_rst_sram_wr_be", sram_wr_byte_en, 0);
        checkOutput("mid_rst_sram_rd_addr", sram_rd_addr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("post_rst_rresp_valid", rresp_valid, 0);
        end
        rresp_ready = 1'b1;
        readWord(9'h030);
        waitDrain();
        checkOutput("post_rst_old_data", lastRespData, 32'hFFFF_FFCF);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
